// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types, FSM encodings and decode helpers for the RV32 load/store unit.
// LSU_MISALIGN_SPLIT_EN (see lsu_mem_ctrl.sv) enables the split-access states.
package lsu_mem_ctrl_pkg;

    typedef enum logic [4:0] {
        GopLoad  = 5'b00000,
        GopStore = 5'b01000
    } gopcode_e;

    typedef enum logic [2:0] {
        F3Lb  = 3'b000,
        F3Lh  = 3'b001,
        F3Lw  = 3'b010,
        F3Lbu = 3'b100,
        F3Lhu = 3'b101
    } f3_ld_e;

    typedef enum logic [2:0] {
        F3Sb = 3'b000,
        F3Sh = 3'b001,
        F3Sw = 3'b010
    } f3_st_e;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCmd   = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StCmd2  = 3'd3;
    localparam logic [2:0] StWait2 = 3'd4;
    localparam logic [2:0] StResp  = 3'd5;

    // Access size in bytes; funct3[1:0] encodes B/H/W for both loads and stores.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic [2:0] size;
        size = size_bytes(funct3);
        return ((size == 3'd2) && (off == 2'd3)) || ((size == 3'd4) && (off != 2'd0));
    endfunction

    function automatic logic illegal_op(input logic [4:0] opcode, input logic [2:0] funct3);
        if (opcode == GopLoad) begin
            return funct3 inside {3'b011, 3'b110, 3'b111};
        end
        if (opcode == GopStore) begin
            return funct3 >= 3'b011;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Byte-lane steering: store strobes/data shift across a word pair and load
// extraction with sign/zero extension from a (possibly two-word) read.
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_lo_i,
    input  logic [31:0] rdata_hi_i,
    output logic [3:0]  wstrb_lo_o,
    output logic [3:0]  wstrb_hi_o,
    output logic [31:0] wdata_lo_o,
    output logic [31:0] wdata_hi_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  strb8;
    logic [63:0] wdata64;
    logic [31:0] ld_word;

    always_comb begin
        // Upper halves spill into the following word for split accesses.
        strb8   = ((8'd1 << size_bytes(funct3_i)) - 8'd1) << off_i;
        wdata64 = {32'd0, wdata_i} << {off_i, 3'b000};
        ld_word = 32'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});

        wstrb_lo_o = strb8[3:0];
        wstrb_hi_o = strb8[7:4];
        wdata_lo_o = wdata64[31:0];
        wdata_hi_o = wdata64[63:32];

        case (funct3_i)
            F3Lb:    load_data_o = {{24{ld_word[7]}}, ld_word[7:0]};
            F3Lh:    load_data_o = {{16{ld_word[15]}}, ld_word[15:0]};
            F3Lw:    load_data_o = ld_word;
            F3Lbu:   load_data_o = {24'd0, ld_word[7:0]};
            F3Lhu:   load_data_o = {16'd0, ld_word[15:0]};
            default: load_data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32 load/store sequencer onto a single word-wide memory port.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two word commands.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [4:0]        req_opcode_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_fault_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_wstrb_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    logic [2:0]        state_q, state_d;
    logic              store_q, store_d;
    logic              fault_q, fault_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata1_q, rdata1_d;
    logic [XLEN-1:0]   rdata2;
    logic              mis_fault;
    logic              need_split;
    logic              second;

    logic [3:0]      wstrb_lo, wstrb_hi;
    logic [XLEN-1:0] wdata_lo, wdata_hi, load_data;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [XLEN-1:0] rdata2_q, rdata2_d;
    assign mis_fault  = 1'b0;
    assign need_split = misaligned(funct3_q, addr_q[1:0]);
    assign second     = (state_q == StCmd2);
    assign rdata2     = rdata2_q;
`else
    assign mis_fault  = misaligned(req_funct3_i, req_addr_i[1:0]);
    assign need_split = 1'b0;
    assign second     = 1'b0;
    assign rdata2     = '0;
`endif

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        fault_d  = fault_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata1_d = rdata1_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        rdata2_d = rdata2_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    store_d  = (req_opcode_i == GopStore);
                    fault_d  = illegal_op(req_opcode_i, req_funct3_i) || mis_fault;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    state_d  = fault_d ? StResp : StCmd;
                end
            end
            StCmd: if (mem_ready_i) state_d = StWait;
            StWait: begin
                if (mem_rvalid_i) begin
                    rdata1_d = mem_rdata_i;
                    state_d  = need_split ? StCmd2 : StResp;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            StCmd2: if (mem_ready_i) state_d = StWait2;
            StWait2: begin
                if (mem_rvalid_i) begin
                    rdata2_d = mem_rdata_i;
                    state_d  = StResp;
                end
            end
`endif
            StResp: if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            store_q  <= 1'b0;
            fault_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata1_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            rdata2_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            fault_q  <= fault_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata1_q <= rdata1_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            rdata2_q <= rdata2_d;
`endif
        end
    end

    lsu_lane_align u_lane_align (
        .funct3_i    (funct3_q),
        .off_i       (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .rdata_lo_i  (rdata1_q),
        .rdata_hi_i  (rdata2),
        .wstrb_lo_o  (wstrb_lo),
        .wstrb_hi_o  (wstrb_hi),
        .wdata_lo_o  (wdata_lo),
        .wdata_hi_o  (wdata_hi),
        .load_data_o (load_data)
    );

    // Everything is decoded from registered state so reset clears outputs at once.
    always_comb begin
        req_ready_o = (state_q == StIdle);
        mem_valid_o = (state_q == StCmd) || (state_q == StCmd2);
        mem_we_o    = mem_valid_o && store_q;
        mem_addr_o  = '0;
        mem_wstrb_o = '0;
        mem_wdata_o = '0;
        if (mem_valid_o) begin
            mem_addr_o = {addr_q[ADDR_W-1:2], 2'b00} + (second ? ADDR_W'(4) : ADDR_W'(0));
        end
        if (mem_we_o) begin
            mem_wstrb_o = second ? wstrb_hi : wstrb_lo;
            mem_wdata_o = second ? wdata_hi : wdata_lo;
        end
        rsp_valid_o = (state_q == StResp);
        rsp_fault_o = rsp_valid_o && fault_q;
        rsp_rdata_o = (rsp_valid_o && !fault_q && !store_q) ? load_data : '0;
    end

endmodule
